traffic_sensor_conditioner: RTL

TRAFFIC_SENSOR_CONDITIONER -- requirements
Module: traffic_sensor_conditioner

---
 rtl/traffic_sensor_conditioner.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/traffic_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : traffic_sensor_conditioner
// Description : Synchronizes and debounces loop/ped/emergency sensors, emits
//               car arrival pulses and an emergency override with fault lockout.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EMG_HOLD        = 8,
    parameter int EMG_MAX         = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       loop_raw,
    input  logic       ped_raw,
    input  logic       emg_raw,
    input  logic       fault_clr,
    output logic       car_detected,
    output logic       emergency,
    output logic       emg_fault,
    output logic [7:0] car_total
);

    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_DUR_W  = $clog2(EMG_MAX + 1);
    localparam int c_HOLD_W = $clog2(EMG_HOLD + 1);

    localparam logic [c_DB_W-1:0]   c_DB_ONE     = c_DB_W'(1);
    localparam logic [c_DB_W-1:0]   c_DB_LIMIT   = c_DB_W'(DEBOUNCE_CYCLES);
    localparam logic [c_DUR_W-1:0]  c_DUR_ONE    = c_DUR_W'(1);
    localparam logic [c_DUR_W-1:0]  c_DUR_LIMIT  = c_DUR_W'(EMG_MAX);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE   = c_HOLD_W'(1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LIMIT = c_HOLD_W'(EMG_HOLD);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_HOLD    = 2'd2,
        S_LOCKOUT = 2'd3
    } emg_state_t;

    // Channel order in the vectors below: [0] loop, [1] ped, [2] emergency
    logic [2:0] w_raw;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] w_deb;
    logic [1:0] r_deb_d;

    assign w_raw = {emg_raw, ped_raw, loop_raw};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_debounce
        logic              r_state;
        logic [c_DB_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= 1'b0;
                r_cnt   <= '0;
            end else if (r_sync2[i] == r_state) begin
                r_cnt <= '0;
            end else if (r_cnt + c_DB_ONE == c_DB_LIMIT) begin
                r_state <= r_sync2[i];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_DB_ONE;
            end
        end

        assign w_deb[i] = r_state;
    end

    // Arrival pulse: one per cycle even if loop and ped qualify together
    logic [1:0] w_rise;
    logic       w_car;
    logic       r_car;
    logic [7:0] r_total;
    logic       r_emergency;

    assign w_rise = w_deb[1:0] & ~r_deb_d;
    assign w_car  = (|w_rise) & ~r_emergency;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_deb_d <= 2'b00;
            r_car   <= 1'b0;
            r_total <= 8'd0;
        end else begin
            r_deb_d <= w_deb[1:0];
            r_car   <= w_car;
            if (w_car && (r_total != 8'hFF)) begin
                r_total <= r_total + 8'd1;
            end
        end
    end

    emg_state_t          r_state;
    emg_state_t          w_next;
    logic [c_DUR_W-1:0]  r_dur;
    logic [c_DUR_W-1:0]  w_dur_next;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_next;
    logic                w_fault_set;
    logic                r_fault;

    always_comb begin
        w_next      = r_state;
        w_dur_next  = r_dur;
        w_hold_next = r_hold;
        w_fault_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_deb[2]) begin
                    w_next     = S_ACTIVE;
                    w_dur_next = '0;
                end
            end
            S_ACTIVE: begin
                w_dur_next = r_dur + c_DUR_ONE;
                // Reaching the duration limit takes priority over a release
                if (w_dur_next == c_DUR_LIMIT) begin
                    w_next      = S_LOCKOUT;
                    w_fault_set = 1'b1;
                end else if (!w_deb[2]) begin
                    w_next      = S_HOLD;
                    w_hold_next = '0;
                end
            end
            S_HOLD: begin
                if (w_deb[2]) begin
                    w_next     = S_ACTIVE;
                    w_dur_next = '0;
                end else begin
                    w_hold_next = r_hold + c_HOLD_ONE;
                    if (w_hold_next == c_HOLD_LIMIT) begin
                        w_next = S_IDLE;
                    end
                end
            end
            S_LOCKOUT: begin
                if (!w_deb[2]) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_dur       <= '0;
            r_hold      <= '0;
            r_emergency <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_dur       <= w_dur_next;
            r_hold      <= w_hold_next;
            r_emergency <= (w_next == S_ACTIVE) || (w_next == S_HOLD);
            r_fault     <= w_fault_set | (r_fault & ~fault_clr);
        end
    end

    assign car_detected = r_car;
    assign emergency    = r_emergency;
    assign emg_fault    = r_fault;
    assign car_total    = r_total;

endmodule
`default_nettype wire
